// File: rtl/qed_pkg.sv
// qed_pkg: shared state encoding and constants for the QED duplicate-mode controller
package qed_pkg;
  typedef enum logic [2:0] {IDLE, ORIG, DRAIN_O, DUP, DRAIN_D, CHECK} qed_state_t;
  localparam logic [31:0] QED_NOP = 32'h0000_0013;
endpackage

// File: rtl/qed_watchdog.sv
// qed_watchdog: down-counter that flags a state held for TIMEOUT counted cycles
module qed_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= W'(TIMEOUT - 1);
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign expired = en && cnt == '0;
endmodule

// File: rtl/qed_dup_ctrl.sv
// qed_dup_ctrl: alternates original and duplicate instruction phases with drains, pair check and watchdog
module qed_dup_ctrl
  import qed_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall_IF,
  input  logic [31:0]      ifu_qed_instruction,
  input  logic             vld_out,
  input  logic             pipe_empty,
  output logic             exec_dup,
  output logic             qed_check,
  output logic             qed_err,
  output logic [CNT_W-1:0] orig_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  qed_state_t state, state_n;
  logic [CNT_W-1:0] orig_n, dup_rem, rem_n;
  logic err_n, accept, replay, watched, expired;
  assign accept = ena && !stall_IF && ifu_qed_instruction != QED_NOP && ifu_qed_instruction != '0;
  assign replay = vld_out && !stall_IF;
  assign watched = state inside {DRAIN_O, DUP, DRAIN_D};
  assign exec_dup = state == DUP;
  assign qed_check = state == CHECK;
  qed_watchdog #(.TIMEOUT(TIMEOUT), .W(WD_W)) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(state_n != state),
    .en(watched),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    orig_n = orig_cnt;
    rem_n = dup_rem;
    err_n = qed_err;
    if (watched && expired) begin
      state_n = IDLE;
      orig_n = '0;
      rem_n = '0;
      err_n = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n = ena ? ORIG : IDLE;
          orig_n = '0;
        end
        ORIG: begin
          if (!ena) state_n = orig_cnt == '0 ? IDLE : DRAIN_O;
          else if (accept && orig_cnt != FULL) begin
            orig_n = orig_cnt + CNT_W'(1);
            state_n = orig_n == FULL ? DRAIN_O : ORIG;
          end
        end
        DRAIN_O: if (pipe_empty) begin
          state_n = orig_cnt == '0 ? IDLE : DUP;
          rem_n = orig_cnt;
        end
        DUP: if (replay && dup_rem != '0) begin
          rem_n = dup_rem - CNT_W'(1);
          state_n = rem_n == '0 ? DRAIN_D : DUP;
        end
        DRAIN_D: state_n = pipe_empty ? CHECK : DRAIN_D;
        CHECK: begin
          state_n = ena ? ORIG : IDLE;
          orig_n = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      orig_cnt <= '0;
      dup_rem <= '0;
      qed_err <= 1'b0;
    end else begin
      state <= state_n;
      orig_cnt <= orig_n;
      dup_rem <= rem_n;
      qed_err <= err_n;
    end
endmodule

// File: tb/tb_qed_dup_ctrl.sv
// tb_qed_dup_ctrl: directed scoreboard bench for the QED duplicate-mode controller
module tb_qed_dup_ctrl;
  localparam logic [31:0] REAL = 32'h0010_0093;
  logic clk, rst, ena, stall_IF, vld_out, pipe_empty;
  logic [31:0] ifu_qed_instruction;
  logic exec_dup, qed_check, qed_err;
  logic [4:0] orig_cnt;
  int n_cmp = 0;
  int n_err = 0;
  int rep_cnt = 0;
  int exp_q[$];
  qed_dup_ctrl dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .stall_IF(stall_IF),
    .ifu_qed_instruction(ifu_qed_instruction),
    .vld_out(vld_out),
    .pipe_empty(pipe_empty),
    .exec_dup(exec_dup),
    .qed_check(qed_check),
    .qed_err(qed_err),
    .orig_cnt(orig_cnt)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic feed(input int n);
    ifu_qed_instruction = REAL;
    for (int i = 0; i < n; i++) tick();
    ifu_qed_instruction = '0;
  endtask
  task automatic enter_dup();
    pipe_empty = 1;
    tick();
    pipe_empty = 0;
    chk("dup_entry", exec_dup, 1);
  endtask
  task automatic replay(input int n, input bit mix, input bit last);
    int k = 0;
    int j = 0;
    while (k < n) begin
      vld_out = 1;
      stall_IF = mix && (j % 2 == 1);
      tick();
      if (!stall_IF) k++;
      j++;
      chk("dup_phase", exec_dup, (k < n || !last) ? 1 : 0);
    end
    vld_out = 0;
    stall_IF = 0;
  endtask
  task automatic finish_pair(input bit ena_after);
    pipe_empty = 1;
    ena = ena_after;
    tick();
    chk("check_pulse", qed_check, 1);
    chk("check_exec", exec_dup, 0);
    pipe_empty = 0;
    tick();
    chk("check_single", qed_check, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) rep_cnt = 0;
    else begin
      if (qed_check) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_check: observed pulse expected none");
        end
        if (exp_q.size() != 0) begin
          int e;
          e = exp_q.pop_front();
          n_cmp++;
          assert (rep_cnt === e) else begin
            n_err++;
            $error("FAIL replay_count: observed %0d expected %0d", rep_cnt, e);
          end
        end
        rep_cnt = 0;
      end
      if (exec_dup && vld_out && !stall_IF) rep_cnt++;
    end
  end
  initial begin
    int exp_cnt;
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      ena = 1'($urandom);
      stall_IF = 1'($urandom);
      vld_out = 1'($urandom);
      pipe_empty = 1'($urandom);
      ifu_qed_instruction = $urandom;
      tick();
    end
    chk("rst_exec", exec_dup, 0);
    chk("rst_check", qed_check, 0);
    chk("rst_err", qed_err, 0);
    chk("rst_cnt", orig_cnt, 0);
    ena = 0; stall_IF = 0; vld_out = 0; pipe_empty = 0; ifu_qed_instruction = '0;
    rst = 1;
    tick();
    ena = 1;
    tick();
    feed(16);
    chk("full_cnt", orig_cnt, 16);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain_o_hold", exec_dup, 0);
    end
    exp_q.push_back(16);
    enter_dup();
    replay(16, 0, 1);
    finish_pair(1);
    chk("orig_after_check", orig_cnt, 0);
    exp_cnt = 0;
    for (int j = 0; j < 64 && exp_cnt < 16; j++) begin
      ifu_qed_instruction = (j % 4 == 0 || j % 4 == 2) ? REAL : (j % 4 == 1 ? 32'h0000_0013 : 32'h0);
      stall_IF = (j % 4 == 2);
      tick();
      if (j % 4 == 0) exp_cnt++;
      chk("filter_cnt", orig_cnt, exp_cnt);
    end
    stall_IF = 0;
    ifu_qed_instruction = '0;
    tick();
    chk("filter_drain", exec_dup, 0);
    exp_q.push_back(16);
    enter_dup();
    replay(16, 1, 1);
    finish_pair(0);
    ifu_qed_instruction = REAL;
    ena = 1;
    tick();
    chk("idle_after_pair", orig_cnt, 0);
    feed(5);
    chk("partial_cnt", orig_cnt, 5);
    ena = 0;
    tick();
    chk("partial_drain", exec_dup, 0);
    chk("partial_hold", orig_cnt, 5);
    exp_q.push_back(5);
    enter_dup();
    replay(5, 0, 1);
    finish_pair(0);
    ifu_qed_instruction = REAL;
    ena = 1;
    tick();
    chk("idle_after_partial", orig_cnt, 0);
    feed(16);
    chk("sat_cnt", orig_cnt, 16);
    exp_q.push_back(16);
    enter_dup();
    replay(2, 0, 0);
    ena = 0;
    replay(14, 0, 1);
    finish_pair(0);
    ifu_qed_instruction = REAL;
    ena = 1;
    tick();
    chk("idle_after_drop", orig_cnt, 0);
    feed(3);
    ena = 0;
    tick();
    for (int i = 0; i < 254; i++) tick();
    chk("wdog_early", qed_err, 0);
    tick();
    chk("wdog_err", qed_err, 1);
    chk("wdog_exec", exec_dup, 0);
    chk("wdog_cnt", orig_cnt, 0);
    ifu_qed_instruction = REAL;
    ena = 1;
    tick();
    chk("wdog_idle", orig_cnt, 0);
    tick();
    chk("wdog_sticky", qed_err, 1);
    chk("after_wdog_cnt", orig_cnt, 1);
    ena = 0;
    ifu_qed_instruction = '0;
    rst = 0;
    tick();
    chk("err_cleared", qed_err, 0);
    rst = 1;
    ena = 1;
    tick();
    feed(16);
    enter_dup();
    rst = 0;
    tick();
    chk("rst_mid_exec", exec_dup, 0);
    chk("rst_mid_cnt", orig_cnt, 0);
    rst = 1;
    ena = 0;
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
